traffic_phase_scheduler: RTL and testbench

- Successor to the combinational largest-lane selector, generalised to N directions × M lanes with a parametrised count width.
- Registered pipeline: per-direction lane sums feed a max-direction selector.
- A phase FSM drives GREEN/YELLOW/ALL_RED sequencing, with minimum- and maximum-green timing and hysteresis.
- Sits between the lane car-count sensors and the signal-head drivers.

---
 rtl/traffic_phase_scheduler_pkg.sv | 28 ++
 rtl/traffic_phase_scheduler_dir_max_select.sv | 28 ++
 rtl/traffic_phase_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and helpers for the traffic phase scheduler: phase encoding,
// direction indices and sum/index width functions.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } phase_t;

  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  // A direction sum needs room for every lane at full scale, and at least one extra bit.
  function automatic int sum_width(input int cnt_w, input int lanes);
    int w;
    w = cnt_w + $clog2(lanes);
    if (w < cnt_w + 1) w = cnt_w + 1;
    return w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_dir_max_select.sv
// Combinational max/argmax over NUM_DIRS direction sums; masked directions are
// skipped and the lowest index wins ties. All-zero or all-masked yields index 0, sum 0.
module dir_max_select
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS = 4,
  parameter int SUM_W    = 9,
  parameter int IDX_W    = idx_width(NUM_DIRS)
) (
  input  logic [NUM_DIRS*SUM_W-1:0] i_sums,
  input  logic [NUM_DIRS-1:0]       i_excl,
  output logic [IDX_W-1:0]          o_max_idx,
  output logic [SUM_W-1:0]          o_max_sum
);

  // Strict greater-than keeps the earlier (lower) index on equal sums.
  always_comb begin
    o_max_idx = '0;
    o_max_sum = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (!i_excl[d] && (i_sums[d*SUM_W +: SUM_W] > o_max_sum)) begin
        o_max_idx = IDX_W'(d);
        o_max_sum = i_sums[d*SUM_W +: SUM_W];
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-stage lane-sum/winner pipeline feeding a GREEN/YELLOW/ALL_RED phase FSM.
// Optional starvation override is enabled with the TPS_STARVATION_EN macro.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS      = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int CNT_W         = 8,
  parameter int MIN_GREEN     = 8,
  parameter int MAX_GREEN     = 32,
  parameter int YELLOW_CYC    = 3
`ifdef TPS_STARVATION_EN
  , parameter int STARVE_LIMIT = 64
`endif
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sample_valid,
  input  logic [NUM_DIRS*LANES_PER_DIR*CNT_W-1:0] lane_cnt,
  output logic [NUM_DIRS-1:0]                     green_oh,
  output logic [NUM_DIRS-1:0]                     yellow_oh,
  output logic [1:0]                              phase,
  output logic                                    switch_pulse
);

  localparam int SUM_W  = sum_width(CNT_W, LANES_PER_DIR);
  localparam int IDX_W  = idx_width(NUM_DIRS);
  localparam int TMR_W  = $clog2(MAX_GREEN + 1);
  localparam int YCNT_W = (YELLOW_CYC > 1) ? $clog2(YELLOW_CYC) : 1;

  logic [NUM_DIRS-1:0][SUM_W-1:0] w_lane_sum;
  logic [NUM_DIRS-1:0][SUM_W-1:0] r_sum;
  logic                           r_sum_vld;
  logic [IDX_W-1:0]               w_dem_idx, w_alt_idx, r_win_idx;
  logic [SUM_W-1:0]               w_dem_sum, w_alt_sum, r_win_sum;
  logic                           r_win_valid;

  phase_t                         r_state;
  logic [IDX_W-1:0]               r_cur, r_target;
  logic [TMR_W-1:0]               r_timer, w_elapsed;
  logic [YCNT_W-1:0]              r_ycnt;
  logic [NUM_DIRS-1:0]            r_green_oh, r_yellow_oh, w_cur_oh, w_target_oh;
  logic                           r_switch_pulse;
  logic                           w_min_ok, w_demand, w_maxg, w_starve;
  logic [IDX_W-1:0]               w_starve_idx;

  always_comb begin
    w_lane_sum = '0;
    for (int d = 0; d < NUM_DIRS; d++)
      for (int l = 0; l < LANES_PER_DIR; l++)
        w_lane_sum[d] = w_lane_sum[d] + SUM_W'(lane_cnt[(d*LANES_PER_DIR+l)*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_sum_vld   <= 1'b0;
      r_win_idx   <= '0;
      r_win_sum   <= '0;
      r_win_valid <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_sum     <= w_lane_sum;
        r_sum_vld <= 1'b1;
      end
      r_win_idx   <= w_dem_idx;
      r_win_sum   <= w_dem_sum;
      r_win_valid <= r_sum_vld;
    end
  end

  dir_max_select #(.NUM_DIRS(NUM_DIRS), .SUM_W(SUM_W), .IDX_W(IDX_W)) u_demand_sel (
    .i_sums    (r_sum),
    .i_excl    ({NUM_DIRS{1'b0}}),
    .o_max_idx (w_dem_idx),
    .o_max_sum (w_dem_sum)
  );

  dir_max_select #(.NUM_DIRS(NUM_DIRS), .SUM_W(SUM_W), .IDX_W(IDX_W)) u_alt_sel (
    .i_sums    (r_sum),
    .i_excl    (w_cur_oh),
    .o_max_idx (w_alt_idx),
    .o_max_sum (w_alt_sum)
  );

  assign w_cur_oh    = NUM_DIRS'(1) << r_cur;
  assign w_target_oh = NUM_DIRS'(1) << r_target;

  // Timing checks use the post-increment count, so GREEN lasts exactly MIN_GREEN
  // (or MAX_GREEN) cycles including its entry cycle.
  assign w_elapsed = (r_timer >= TMR_W'(MAX_GREEN)) ? TMR_W'(MAX_GREEN) : r_timer + 1'b1;
  assign w_min_ok  = (w_elapsed >= TMR_W'(MIN_GREEN));
  assign w_demand  = w_min_ok && r_win_valid && (r_win_idx != r_cur) && (r_win_sum > r_sum[r_cur]);
  assign w_maxg    = (w_elapsed == TMR_W'(MAX_GREEN)) && (w_alt_sum != '0);

`ifdef TPS_STARVATION_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [NUM_DIRS-1:0][WAIT_W-1:0] r_wait;
  logic                            w_starve_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else begin
      for (int d = 0; d < NUM_DIRS; d++) begin
        if (r_state == GREEN && IDX_W'(d) == r_cur)
          r_wait[d] <= '0;
        else if (r_sum[d] != '0 && r_wait[d] != WAIT_W'(STARVE_LIMIT))
          r_wait[d] <= r_wait[d] + 1'b1;
      end
    end
  end

  // Scan high-to-low so the lowest starved index is the one left standing.
  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_idx = '0;
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (r_wait[d] == WAIT_W'(STARVE_LIMIT) && IDX_W'(d) != r_cur) begin
        w_starve_hit = 1'b1;
        w_starve_idx = IDX_W'(d);
      end
    end
  end

  assign w_starve = w_min_ok && w_starve_hit;
`else
  assign w_starve     = 1'b0;
  assign w_starve_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ALL_RED;
      r_cur          <= '0;
      r_target       <= '0;
      r_timer        <= '0;
      r_ycnt         <= '0;
      r_green_oh     <= '0;
      r_yellow_oh    <= '0;
      r_switch_pulse <= 1'b0;
    end else begin
      r_switch_pulse <= 1'b0;
      unique case (r_state)
        ALL_RED: begin
          r_state        <= GREEN;
          r_cur          <= r_target;
          r_timer        <= '0;
          r_green_oh     <= w_target_oh;
          r_switch_pulse <= 1'b1;
        end
        GREEN: begin
          r_timer <= w_elapsed;
          if (w_starve || w_demand || w_maxg) begin
            if (w_starve)      r_target <= w_starve_idx;
            else if (w_demand) r_target <= r_win_idx;
            else               r_target <= w_alt_idx;
            r_state     <= YELLOW;
            r_green_oh  <= '0;
            r_yellow_oh <= w_cur_oh;
            r_ycnt      <= '0;
          end
        end
        YELLOW: begin
          if (r_ycnt == YCNT_W'(YELLOW_CYC - 1)) begin
            r_state     <= ALL_RED;
            r_yellow_oh <= '0;
          end else begin
            r_ycnt <= r_ycnt + 1'b1;
          end
        end
        default: r_state <= ALL_RED;
      endcase
    end
  end

  assign green_oh     = r_green_oh;
  assign yellow_oh    = r_yellow_oh;
  assign phase        = r_state;
  assign switch_pulse = r_switch_pulse;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Table-driven bench for traffic_phase_scheduler: each record drives inputs for a
// number of cycles and states the outputs expected after every one of those edges.
module tb_traffic_phase_scheduler;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [63:0] lane_cnt;
  logic [3:0]  green_oh;
  logic [3:0]  yellow_oh;
  logic [1:0]  phase;
  logic        switch_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [63:0] lanes;
    int          reps;
    logic [1:0]  ph;
    logic [3:0]  g;
    logic [3:0]  y;
    logic        p;
  } vec_t;

  vec_t vecs[$];

  traffic_phase_scheduler #(
    .NUM_DIRS(4), .LANES_PER_DIR(2), .CNT_W(8),
    .MIN_GREEN(8), .MAX_GREEN(32), .YELLOW_CYC(3)
`ifdef TPS_STARVATION_EN
    , .STARVE_LIMIT(16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .lane_cnt     (lane_cnt),
    .green_oh     (green_oh),
    .yellow_oh    (yellow_oh),
    .phase        (phase),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane order within the flat bus is N0,N1,E0,E1,S0,S1,W0,W1 from the LSB up.
  function automatic logic [63:0] mk(input logic [7:0] n0, n1, e0, e1, s0, s1, w0, w1);
    return {w1, w0, s1, s0, e1, e0, n1, n0};
  endfunction

  task automatic addVec(input logic r, input logic sv, input logic [63:0] ln, input int reps,
                        input logic [1:0] ph, input logic [3:0] g, input logic [3:0] y, input logic p);
    vec_t v;
    v.rst = r; v.sv = sv; v.lanes = ln; v.reps = reps;
    v.ph = ph; v.g = g; v.y = y; v.p = p;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx, input int rep,
                             input logic [3:0] actual, input logic [3:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d rep=%0d got=%b want=%b", name, idx, rep, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    rst          = vecs[idx].rst;
    sample_valid = vecs[idx].sv;
    lane_cnt     = vecs[idx].lanes;
    for (int r = 0; r < vecs[idx].reps; r++) begin
      @(posedge clk);
      #1;
      checkOutput("phase",  idx, r, {2'b00, phase},        {2'b00, vecs[idx].ph});
      checkOutput("green",  idx, r, green_oh,              vecs[idx].g);
      checkOutput("yellow", idx, r, yellow_oh,             vecs[idx].y);
      checkOutput("pulse",  idx, r, {3'b000, switch_pulse}, {3'b000, vecs[idx].p});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] d1, d2, d3, d4, d5, d6, s1;
    rst          = 1'b1;
    sample_valid = 1'b0;
    lane_cnt     = '0;

    d1 = mk(8'd1, 8'd1, 8'd50, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0);
    d2 = mk(8'd0, 8'd0, 8'd50, 8'd60, 8'd55, 8'd55, 8'd0, 8'd0);
    d3 = mk(8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0);
    d4 = {8{8'd255}};
    d5 = mk(8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    d6 = mk(8'd9, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    s1 = mk(8'd255, 8'd255, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0);

`ifdef TPS_STARVATION_EN
    // N=510 keeps its green against demand; S=1 is served once its wait hits 16.
    addVec(1, 1, s1,  2, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, s1,  1, 2'b01, 4'b0001, 4'b0000, 1);
    addVec(0, 1, s1, 16, 2'b01, 4'b0001, 4'b0000, 0);
    addVec(0, 1, s1,  3, 2'b10, 4'b0000, 4'b0001, 0);
    addVec(0, 1, s1,  1, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, s1,  1, 2'b01, 4'b0100, 4'b0000, 1);
`else
    // Reset, then demand switch N -> E after exactly MIN_GREEN cycles.
    addVec(1, 1, d1,  2, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, d1,  1, 2'b01, 4'b0001, 4'b0000, 1);
    addVec(0, 1, d1,  7, 2'b01, 4'b0001, 4'b0000, 0);
    addVec(0, 1, d1,  3, 2'b10, 4'b0000, 4'b0001, 0);
    addVec(0, 1, d1,  1, 2'b00, 4'b0000, 4'b0000, 0);
    // E=110 ties S=110: hold to MAX_GREEN, then S.
    addVec(0, 1, d2,  1, 2'b01, 4'b0010, 4'b0000, 1);
    addVec(0, 1, d2, 31, 2'b01, 4'b0010, 4'b0000, 0);
    addVec(0, 1, d2,  3, 2'b10, 4'b0000, 4'b0010, 0);
    addVec(0, 1, d2,  1, 2'b00, 4'b0000, 4'b0000, 0);
    // S empty, N=200 wins on demand; then N holds to MAX_GREEN and yields to W=1.
    addVec(0, 1, d3,  1, 2'b01, 4'b0100, 4'b0000, 1);
    addVec(0, 1, d3,  7, 2'b01, 4'b0100, 4'b0000, 0);
    addVec(0, 1, d3,  3, 2'b10, 4'b0000, 4'b0100, 0);
    addVec(0, 1, d3,  1, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, d3,  1, 2'b01, 4'b0001, 4'b0000, 1);
    addVec(0, 1, d3, 31, 2'b01, 4'b0001, 4'b0000, 0);
    addVec(0, 1, d3,  3, 2'b10, 4'b0000, 4'b0001, 0);
    addVec(0, 1, d3,  1, 2'b00, 4'b0000, 4'b0000, 0);
    // All lanes 255 (sums 510): W -> N, then N -> E by lowest non-current index.
    addVec(0, 1, d4,  1, 2'b01, 4'b1000, 4'b0000, 1);
    addVec(0, 1, d4, 31, 2'b01, 4'b1000, 4'b0000, 0);
    addVec(0, 1, d4,  3, 2'b10, 4'b0000, 4'b1000, 0);
    addVec(0, 1, d4,  1, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, d4,  1, 2'b01, 4'b0001, 4'b0000, 1);
    addVec(0, 1, d4, 31, 2'b01, 4'b0001, 4'b0000, 0);
    addVec(0, 1, d4,  3, 2'b10, 4'b0000, 4'b0001, 0);
    addVec(0, 1, d4,  1, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, d4,  1, 2'b01, 4'b0010, 4'b0000, 1);
    // Only E non-zero: green persists past MAX_GREEN; held sums ignore new lanes.
    addVec(0, 1, d5, 40, 2'b01, 4'b0010, 4'b0000, 0);
    addVec(0, 0, d6,  5, 2'b01, 4'b0010, 4'b0000, 0);
    addVec(0, 1, d6,  1, 2'b01, 4'b0010, 4'b0000, 0);
    addVec(0, 1, d6,  3, 2'b10, 4'b0000, 4'b0010, 0);
    addVec(0, 1, d6,  1, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, d6,  1, 2'b01, 4'b0001, 4'b0000, 1);
    // Reset in the middle of GREEN.
    addVec(1, 1, d6,  1, 2'b00, 4'b0000, 4'b0000, 0);
    addVec(0, 1, d6,  1, 2'b01, 4'b0001, 4'b0000, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
